// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - in-order instruction fetch with address queue and output buffer
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
module fetch_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              stall,
    output logic              fetch_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] aq_addr [DEPTH];
    logic [PW-1:0]     aq_wr;
    logic [PW-1:0]     aq_rd;
    logic [CW-1:0]     out_cnt;
    logic [CW-1:0]     disc_cnt;

    logic [DATA_W-1:0] bq_instr [DEPTH];
    logic [ADDR_W-1:0] bq_pc    [DEPTH];
    logic [PW-1:0]     bq_wr;
    logic [PW-1:0]     bq_rd;
    logic [CW-1:0]     buf_cnt;

    logic [DATA_W-1:0] last_instr;
    logic [ADDR_W-1:0] last_pc;

    logic [CW-1:0]     occ;
    logic              accept;
    logic              resp;
    logic              keep;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              buf_empty;

    assign occ       = out_cnt + buf_cnt;
    assign buf_empty = (buf_cnt == '0);

    // Requests are masked while reset is held so the PC sees a stall until reset releases.
    assign imem_req    = reset & (occ < FULL) & ~flush;
    assign imem_addr   = pc;
    assign accept      = imem_req & imem_gnt;
    assign fetch_stall = ~accept;

    assign resp = imem_rvalid & (out_cnt != '0);
    assign keep = resp & (disc_cnt == '0) & ~flush;

`ifdef FETCH_BYPASS_EN
    assign bypass = keep & buf_empty & ~stall;
`else
    assign bypass = 1'b0;
`endif

    assign push = keep & ~bypass;
    assign pop  = ~buf_empty & ~stall & ~flush;

    always_comb begin
        if_valid = 1'b0;
        if_instr = last_instr;
        if_pc    = last_pc;
        if (!buf_empty) begin
            if_valid = 1'b1;
            if_instr = bq_instr[bq_rd];
            if_pc    = bq_pc[bq_rd];
        end else if (bypass) begin
            if_valid = 1'b1;
            if_instr = imem_rdata;
            if_pc    = aq_addr[aq_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            aq_addr[aq_wr] <= pc;
        end
        if (push) begin
            bq_instr[bq_wr] <= imem_rdata;
            bq_pc[bq_wr]    <= aq_addr[aq_rd];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aq_wr      <= '0;
            aq_rd      <= '0;
            out_cnt    <= '0;
            disc_cnt   <= '0;
            bq_wr      <= '0;
            bq_rd      <= '0;
            buf_cnt    <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else begin
            if (accept) begin
                aq_wr <= aq_wr + 1'b1;
            end
            if (resp) begin
                aq_rd <= aq_rd + 1'b1;
            end
            out_cnt <= out_cnt + CW'(accept) - CW'(resp);

            // Everything still in flight after this edge belongs to the old path.
            if (flush) begin
                disc_cnt <= out_cnt - CW'(resp);
            end else if (resp && disc_cnt != '0) begin
                disc_cnt <= disc_cnt - 1'b1;
            end

            if (flush) begin
                bq_wr   <= '0;
                bq_rd   <= '0;
                buf_cnt <= '0;
            end else begin
                if (push) begin
                    bq_wr <= bq_wr + 1'b1;
                end
                if (pop) begin
                    bq_rd <= bq_rd + 1'b1;
                end
                buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
            end

            if (if_valid) begin
                last_instr <= if_instr;
                last_pc    <= if_pc;
            end
        end
    end

`ifndef SYNTHESIS
    rvalid_without_request: assert property (
        @(posedge clk) disable iff (!reset) !(imem_rvalid && out_cnt == '0));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized fetch_stage bench against a queue-based reference model
module tb_fetch_stage;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          flush;
    logic          stall;
    logic          fetch_stall;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .stall       (stall),
        .fetch_stall (fetch_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    typedef struct {
        logic [DW-1:0] data;
        int            ready;
    } mreq_t;

    ent_t          bufq[$];
    logic [AW-1:0] outq[$];
    mreq_t         memq[$];
    int            disc;
    logic [DW-1:0] last_instr;
    logic [AW-1:0] last_pc;
    int            cyc;
    int            nflush;
    logic          tog;
    int            checks;
    int            failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        flush       = 1'b0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pc          = '0;
        #1;
        chk("reset_req", 64'(imem_req), 64'd0);
        chk("reset_fetch_stall", 64'(fetch_stall), 64'd1);
        chk("reset_if_valid", 64'(if_valid), 64'd0);
        chk("reset_if_instr", 64'(if_instr), 64'd0);
        chk("reset_if_pc", 64'(if_pc), 64'd0);
        bufq.delete();
        outq.delete();
        memq.delete();
        disc       = 0;
        last_instr = '0;
        last_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic step(input int gnt_pct, input int kmax, input int stall_pct,
                        input int flush_pct, input bit toggle);
        int            occ;
        bit            e_req, acc, resp, keep, byp, e_valid;
        logic [DW-1:0] e_instr;
        logic [AW-1:0] e_pc, a, pc_next;
        mreq_t         m;

        if (toggle) begin
            tog      = ~tog;
            imem_gnt = tog;
        end else begin
            imem_gnt = ($urandom % 100) < gnt_pct;
        end
        stall = ($urandom % 100) < stall_pct;
        flush = ($urandom % 100) < flush_pct;
        if (memq.size() > 0 && memq[0].ready <= cyc && ($urandom % 100) < 80) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memq[0].data;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #2;

        occ   = outq.size() + bufq.size();
        e_req = (occ < DEPTH) && !flush;
        acc   = e_req && imem_gnt;
        resp  = imem_rvalid && outq.size() > 0;
        keep  = resp && disc == 0 && !flush;
        byp   = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = keep && bufq.size() == 0 && !stall;
`endif
        if (bufq.size() > 0) begin
            e_valid = 1'b1;
            e_instr = bufq[0].instr;
            e_pc    = bufq[0].pc;
        end else if (byp) begin
            e_valid = 1'b1;
            e_instr = imem_rdata;
            e_pc    = outq[0];
        end else begin
            e_valid = 1'b0;
            e_instr = last_instr;
            e_pc    = last_pc;
        end

        chk("imem_req", 64'(imem_req), 64'(e_req));
        chk("imem_addr", 64'(imem_addr), 64'(pc));
        chk("fetch_stall", 64'(fetch_stall), 64'(!acc));
        chk("if_valid", 64'(if_valid), 64'(e_valid));
        chk("if_instr", 64'(if_instr), 64'(e_instr));
        chk("if_pc", 64'(if_pc), 64'(e_pc));

        if (e_valid) begin
            last_instr = e_instr;
            last_pc    = e_pc;
        end
        if (bufq.size() > 0 && !stall && !flush) begin
            void'(bufq.pop_front());
        end
        if (resp) begin
            a = outq.pop_front();
            if (disc > 0) begin
                disc--;
            end else if (!flush && !byp) begin
                bufq.push_back('{imem_rdata, a});
            end
        end
        if (imem_rvalid) begin
            void'(memq.pop_front());
        end
        if (flush) begin
            bufq.delete();
            disc = outq.size();
        end
        if (acc) begin
            outq.push_back(pc);
            m.data  = $urandom;
            m.ready = cyc + $urandom_range(1, kmax);
            memq.push_back(m);
        end

        pc_next = pc;
        if (flush) begin
            pc_next = (nflush == 0) ? 32'h100 : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            nflush++;
        end else if (acc) begin
            pc_next = pc + 32'd4;
        end
        @(posedge clk);
        #1;
        pc = pc_next;
        cyc++;
    endtask

    task automatic run(input int n, input int gnt_pct, input int kmax, input int stall_pct,
                       input int flush_pct, input bit toggle);
        for (int i = 0; i < n; i++) begin
            step(gnt_pct, kmax, stall_pct, flush_pct, toggle);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        nflush   = 0;
        tog      = 1'b0;
        do_reset();
        run(12, 100, 1, 0, 0, 1'b0);
        run(6, 100, 1, 100, 0, 1'b0);
        run(10, 100, 1, 0, 0, 1'b0);
        run(4, 100, 3, 0, 0, 1'b0);
        step(100, 3, 0, 100, 1'b0);
        run(12, 100, 3, 0, 0, 1'b0);
        run(30, 100, 1, 30, 20, 1'b0);
        run(10, 0, 1, 0, 0, 1'b1);
        run(400, 60, 4, 30, 5, 1'b0);
        do_reset();
        run(200, 70, 3, 40, 8, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, directly downstream of the program counter.
- Takes the current PC, issues in-order requests to instruction memory over a req/gnt + rvalid interface, and buffers the returned instructions with their PCs.
- Presents them to decode under a valid/stall handshake.
- Back-pressures the program counter via `fetch_stall`, and discards in-flight fetches on a redirect (branch/jump flush).

Parameters:
- `ADDR_W`, 32, PC / instruction-memory address width.
- `DATA_W`, 32, instruction word width.
- `DEPTH`, 2, max fetches held (outstanding + buffered); power of two, >= 2.

Ports:
- `clk`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `pc`  input  `ADDR_W`  current PC from program counter.
- `flush`  input  1  redirect; asserted the cycle target_enable loads a new PC.
- `stall`  input  1  decode not ready; holds current output entry.
- `fetch_stall`  output  1  to program counter stall; high = PC must not advance.
- `imem_req`  output  1  fetch request valid.
- `imem_addr`  output  `ADDR_W`  fetch address (= `pc`).
- `imem_gnt`  input  1  memory accepts request this cycle.
- `imem_rvalid`  input  1  response valid (in request order, >= 1 cycle after gnt).
- `imem_rdata`  input  `DATA_W`  instruction word.
- `if_valid`  output  1  output entry valid.
- `if_instr`  output  `DATA_W`  instruction to decode.
- `if_pc`  output  `ADDR_W`  PC of `if_instr`.

Behaviour:
- **Reset** (`reset` low, async): buffer and address queue empty, counters 0.
  - Outputs: `imem_req`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `fetch_stall`=1.
  - Leaving reset: first request at the first rising edge with `reset` high.
- **Occupancy:** `occ` = outstanding + buffered, range 0..`DEPTH`.
- **Requests:**
  - `imem_req` = (`occ` < `DEPTH`) & ~`flush`.
  - `imem_addr` = `pc`, combinational.
  - Accept = `imem_req` & `imem_gnt`; on accept, `pc` is pushed into the address queue.
- **PC advance:** `fetch_stall` = ~accept. The PC advances exactly once per accepted request; no PC value is skipped or duplicated.
- **Responses:**
  - On `imem_rvalid` with `discard_cnt`=0: pop the address queue and push {`imem_rdata`, addr} into the output buffer.
  - Response with `discard_cnt`>0: decrement `discard_cnt`, pop the queue, drop the data.
  - `imem_rvalid` with no outstanding request is a protocol error: ignored, flagged by simulation assertion.
- **Output:**
  - `if_valid` = buffer non-empty; `if_instr`/`if_pc` = head entry.
  - Pop when `if_valid` & ~`stall`.
  - While `stall` is high, the head entry is held stable.
- **Latency:** gnt in cycle N, rvalid in cycle N+k gives `if_valid` in cycle N+k+1 (registered).
- **Flush:**
  - Same edge: output buffer cleared, `discard_cnt` += outstanding count, no request issued (`imem_req`=0).
  - `if_valid`=0 the following cycle.
  - New requests resume the next cycle from the redirected `pc`.
  - Flush and pop in the same cycle: flush wins.
  - Flush coinciding with a response: the response is discarded.
- **Simultaneous accept + response + pop:** all take effect; `occ` updates by the net amount.
- **Full** (`occ`=`DEPTH`): `imem_req`=0, `fetch_stall`=1.
- **Empty:** `if_valid`=0, and `if_instr`/`if_pc` hold their last values.
- **Wrap-around:** queue pointers wrap modulo `DEPTH`; PC arithmetic is not performed here.
- **Reset mid-operation:** all in-flight responses are forgotten. Memory must be reset on the same reset.

Optional Feature:
- Macro: `FETCH_BYPASS_EN`.
- **Defined:** a non-discarded response arriving while the buffer is empty and `stall`=0 drives `if_valid`/`if_instr`/`if_pc` combinationally in the same cycle and is not written to the buffer. Latency drops to N+k.
- **Undefined:** all responses are registered, with latency N+k+1 as above.

Test Plan:
- **Reset then fixed latency:** memory `gnt`=1, k=1, pc 0,4,8 → `if_pc` 0,4,8 on consecutive cycles starting cycle 3; `fetch_stall` low after the first accept.
- **Back-pressure:** hold `stall`=1 for 5 cycles with `DEPTH`=2 → `imem_req` drops after 2 accepts, `fetch_stall`=1, `if_pc`=0 stable. Release → 4 then 8 follow, with no gap or duplicate.
- **Flush with 2 outstanding** (k=3) → both responses dropped, `if_valid`=0. The first `if_pc` after redirect to 0x100 is 0x100.
- **Flush + pop + response in the same cycle** → entry not consumed, response dropped, `if_valid`=0 the next cycle.
- **gnt throttling** (`gnt` toggles 1,0,1,0) → PC advances only on accepted cycles; `imem_addr` sequence 0,4,4,8,8.
- **`FETCH_BYPASS_EN` defined,** k=1, buffer empty, `stall`=0 → `if_valid` asserts in the rvalid cycle with `if_instr`=`imem_rdata`.
